// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared FU encoding and CDB sizing constants
package cdb_arbiter_pkg;

    // Same encoding as the issuer's function field.
    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_BPU = 2'd2,
        FU_CSR = 2'd3
    } fu_idx_e;

    localparam int CDB_FU_NUM     = 4;
    localparam int CDB_ROB_ENTRY  = 4;
    localparam int CDB_DATA_WIDTH = 32;
    localparam int CDB_ROB_TAG_W  = $clog2(CDB_ROB_ENTRY);
    localparam int CDB_FU_IDX_W   = $clog2(CDB_FU_NUM);

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rtl/cdb_arbiter_rr_arbiter.sv - generic combinational N-way round-robin grant
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    logic w_found;

    // Scan from ptr upward, wrapping; the first requester found wins.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                gnt[j]  = 1'b1;
                idx     = W'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB round-robin arbiter with registered broadcast; option CDB_ARB_LSU_PRIORITY_EN
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FU_NUM         = CDB_FU_NUM,
    parameter int ROB_ENTRY      = CDB_ROB_ENTRY,
    parameter int DATA_WIDTH     = CDB_DATA_WIDTH,
    parameter int ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY),
    parameter int FU_NUM_LOG2    = $clog2(FU_NUM)
) (
    input  logic                             CLK,
    input  logic                             RSTN,
    input  logic [FU_NUM-1:0]                fu_valid,
    output logic [FU_NUM-1:0]                fu_ready,
    input  logic [FU_NUM*ROB_ENTRY_LOG2-1:0] fu_rob_id,
    input  logic [FU_NUM*DATA_WIDTH-1:0]     fu_data,
    input  logic                             flush,
    output logic                             cdb_valid,
    output logic [ROB_ENTRY_LOG2-1:0]        cdb_rob_id,
    output logic [DATA_WIDTH-1:0]            cdb_data,
    output logic [FU_NUM_LOG2-1:0]           cdb_src
);

    logic [FU_NUM_LOG2-1:0] r_rr_ptr;
    logic [FU_NUM-1:0]      w_rr_gnt;
    logic [FU_NUM_LOG2-1:0] w_rr_idx;
    logic [FU_NUM-1:0]      w_sel_gnt;
    logic [FU_NUM_LOG2-1:0] w_sel_idx;
    logic [FU_NUM_LOG2-1:0] w_ptr_next;
    logic                   w_xfer;
    logic                   w_ptr_upd;

    rr_arbiter #(
        .N (FU_NUM),
        .W (FU_NUM_LOG2)
    ) u_rr_arbiter (
        .req (fu_valid),
        .ptr (r_rr_ptr),
        .gnt (w_rr_gnt),
        .idx (w_rr_idx)
    );

`ifdef CDB_ARB_LSU_PRIORITY_EN
    localparam logic [FU_NUM_LOG2-1:0] LSU_IDX = FU_NUM_LOG2'(FU_LSU);

    // LSU pre-empts the ring without consuming a round-robin turn.
    always_comb begin
        w_sel_gnt = w_rr_gnt;
        w_sel_idx = w_rr_idx;
        if (fu_valid[LSU_IDX]) begin
            w_sel_gnt          = '0;
            w_sel_gnt[LSU_IDX] = 1'b1;
            w_sel_idx          = LSU_IDX;
        end
    end

    assign w_ptr_upd = w_xfer && (w_sel_idx != LSU_IDX);
`else
    assign w_sel_gnt = w_rr_gnt;
    assign w_sel_idx = w_rr_idx;
    assign w_ptr_upd = w_xfer;
`endif

    assign fu_ready   = (RSTN && !flush) ? w_sel_gnt : '0;
    assign w_xfer     = |fu_ready;
    assign w_ptr_next = (w_sel_idx == FU_NUM_LOG2'(FU_NUM - 1)) ? '0 : w_sel_idx + 1'b1;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rr_ptr <= '0;
        end else if (w_ptr_upd) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    // Payload holds when idle; only the valid strobe drops.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_data   <= '0;
            cdb_src    <= '0;
        end else begin
            cdb_valid <= w_xfer;
            if (w_xfer) begin
                cdb_rob_id <= fu_rob_id[int'(w_sel_idx)*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2];
                cdb_data   <= fu_data[int'(w_sel_idx)*DATA_WIDTH +: DATA_WIDTH];
                cdb_src    <= w_sel_idx;
            end
        end
    end

endmodule
